uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial UART transmitter for the UART_protocol subsystem. It is the transmit-side counterpart of the receive FSM/datapath. It accepts a parallel byte over a valid/ready handshake and serialises it LSB-first onto o_tx as a frame: start bit (0), DATA_WIDTH data bits, optional parity bit, one stop bit (1). It contains its own bit-period counter, bit index counter, shift register and parity generator, so the output frame is directly compatible with the receiver's start-detect, parity-check and stop-check sequence.

Parameters:
CLKS_PER_BIT, 16, i_clk cycles per serial bit; legal range is 2 or more.
DATA_WIDTH, 8, data bits per frame; legal range is 5 to 9.
PARITY_EN, 1, 1 inserts a parity bit after the data bits; 0 omits it.
PARITY_ODD, 0, 0 selects even parity; 1 selects odd parity. Ignored when PARITY_EN=0.

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-low reset
i_data  input  DATA_WIDTH  byte to transmit; sampled only on accept
i_valid  input  1  i_data is valid
o_ready  output  1  block can accept a byte
o_tx  output  1  serial line; idle level is 1
o_busy  output  1  a frame is in progress
o_done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Reset (i_reset=0, asynchronous):
  - o_tx=1, o_ready=1, o_busy=0, o_done=0.
  - State IDLE; bit counter, bit index and shift register all 0.
  - Reset mid-frame aborts the frame: o_tx returns to 1 immediately, and no o_done is issued.
- All outputs are registered; there are no combinational input-to-output paths.
- Accept:
  - A byte is accepted at a rising edge where i_valid=1 and o_ready=1.
  - Only in that cycle are i_data latched into the shift register and parity computed: parity = XOR(i_data) ^ PARITY_ODD.
  - Changes to i_data while busy are ignored.
  - i_valid while o_ready=0 is ignored; there is no queueing and no error flag.
- State machine. Let accept edge = k, N = DATA_WIDTH + PARITY_EN + 2, C = CLKS_PER_BIT.
  - IDLE: o_ready=1, o_busy=0, o_tx=1. On accept go to START; from the edge after accept, o_tx=0, o_ready=0, o_busy=1.
  - START: hold o_tx=0 for C cycles, then go to DATA.
  - DATA: drive shift-register bit 0; every C cycles shift right and increment the bit index. After DATA_WIDTH bits go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: drive the latched parity bit for C cycles, then go to STOP.
  - STOP: drive o_tx=1 for C cycles, then return to IDLE.
- Timing:
  - Each bit occupies exactly C cycles. Bit j of the frame (start = 0) is driven from edge k + j*C to edge k + (j+1)*C.
  - At edge k + N*C the block returns to IDLE: o_ready=1, o_busy=0, o_tx=1, and o_done=1 for exactly one cycle.
- Back-to-back: with i_valid held high, the next accept happens at edge k + N*C + 1. This gives exactly one extra idle (1) cycle between frames, so frame period = N*C + 1 cycles.
- Counters:
  - The bit-period counter counts 0..C-1 and wraps; the state advances on the terminal count.
  - The counter is cleared on accept and on every state change.
  - Counter width is clog2(CLKS_PER_BIT).
- Illegal or unused state encodings go to IDLE with reset output values.

Test Plan:
1. Reset then idle, 20 cycles with i_valid=0 -> o_tx=1, o_ready=1, o_busy=0, o_done=0 throughout.
2. Defaults (C=16, even parity), send 0xA5 -> o_tx sampled mid-bit = 0,1,0,1,0,0,1,0,1,0(parity),1(stop). o_busy high for 176 cycles; o_done pulses once at edge k+176.
3. PARITY_ODD=1, send 0x00 -> parity bit = 1. PARITY_EN=0, send 0xFF -> frame = 0, eight 1s, 1; frame length 160 cycles with no parity slot.
4. i_valid held high with data 0x3C then 0xC3 -> two correct frames separated by exactly 1 idle-high cycle. Toggling i_data mid-frame does not alter the first frame's bits.
5. Assert i_reset during data bit 3 of a frame -> o_tx=1 asynchronously, no o_done. After release, o_ready=1 and a new frame of 0x55 transmits correctly.
6. Loopback: o_tx feeds the team's receiver at matching CLKS_PER_BIT; send 256 random bytes -> all received bytes match, no parity errors, every stop check passes.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: serialises one DATA_WIDTH-bit word per frame, LSB first,
//   framed as start(0), data, optional parity, stop(1).
// Latency: o_tx drops to the start bit on the edge after accept; a frame lasts
//   N*CLKS_PER_BIT cycles (N = DATA_WIDTH + PARITY_EN + 2), o_done pulses on return to idle.
// Backpressure: o_ready is low for the whole frame; i_valid while not ready is
//   dropped, no queueing. Back-to-back accepts are spaced N*CLKS_PER_BIT + 1 cycles.
//
// Ports:
//   i_clk, i_reset  clock, asynchronous active-low reset
//   i_data, i_valid word to send and its qualifier (sampled only on accept)
//   o_ready         can accept a word this cycle
//   o_tx            serial line, idles high
//   o_busy          frame in progress
//   o_done          one-cycle pulse when the stop bit has completed
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);
  localparam logic          PAR_INIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  par_q, par_d;
  logic                  tx_d, rdy_d, busy_d, done_d;
  logic                  cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      o_tx    <= 1'b1;
      o_ready <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      o_tx    <= tx_d;
      o_ready <= rdy_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
    end
  end

  // Outputs are computed one cycle ahead so that every output is a flop.
  // The bit counter wraps on its terminal count, which is also the only point
  // where the state (or the data bit index) advances, so it is always zero
  // right after a state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = o_tx;
    rdy_d   = o_ready;
    busy_d  = o_busy;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        rdy_d  = 1'b1;
        busy_d = 1'b0;
        if (i_valid && o_ready) begin
          state_d = S_START;
          sh_d    = i_data;
          par_d   = (^i_data) ^ PAR_INIT;
          idx_d   = '0;
          tx_d    = 1'b0;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        if (cnt_last) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = sh_q[0];
        end
      end

      S_DATA: begin
        if (cnt_last) begin
          if (idx_q == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // The next bit is sh_q[1]; it becomes bit 0 once the shift lands.
            sh_d  = sh_q >> 1;
            idx_d = idx_q + 1'b1;
            tx_d  = sh_q[1];
          end
        end
      end

      S_PARITY: begin
        if (cnt_last) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_last) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        sh_d    = '0;
        par_d   = 1'b0;
        tx_d    = 1'b1;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations (default even parity, odd parity,
//   no parity, short bit period for a loopback receiver model).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       vld  [4];
  logic [7:0] dat  [4];
  logic       rdy  [4];
  logic       tx   [4];
  logic       busy [4];
  logic       done [4];

  int total = 0;
  int bad   = 0;

  uart_tx u0 (
    .i_clk(clk), .i_reset(rst_n), .i_data(dat[0]), .i_valid(vld[0]),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0])
  );
  uart_tx #(.PARITY_ODD(1)) u1 (
    .i_clk(clk), .i_reset(rst_n), .i_data(dat[1]), .i_valid(vld[1]),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1])
  );
  uart_tx #(.PARITY_EN(0)) u2 (
    .i_clk(clk), .i_reset(rst_n), .i_data(dat[2]), .i_valid(vld[2]),
    .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2])
  );
  uart_tx #(.CLKS_PER_BIT(4)) u3 (
    .i_clk(clk), .i_reset(rst_n), .i_data(dat[3]), .i_valid(vld[3]),
    .o_ready(rdy[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_done(done[3])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one word on instance u and checks the frame bit by bit at mid-bit,
  // the busy length, and the single done pulse at the end. Returns on the
  // falling edge right after the return to idle. keep_vld leaves i_valid high
  // so the caller can chain the next frame; junk overwrites i_data mid-frame.
  task automatic run_frame(input int u, input int c, input bit pen, input bit podd,
                           input logic [7:0] b, input bit keep_vld,
                           input logic [7:0] junk, input string tag);
    int         n;
    int         busy_cnt;
    int         done_cnt;
    logic [10:0] exp_bits;
    n = 10 + int'(pen);
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
    if (pen) exp_bits[9] = (^b) ^ podd;
    dat[u] = b;
    vld[u] = 1'b1;
    @(negedge clk);
    if (!keep_vld) vld[u] = 1'b0;
    dat[u] = junk;
    check({tag, " accept tx/busy/rdy"}, 32'({tx[u], busy[u], rdy[u]}), 32'b010);
    busy_cnt = 0;
    done_cnt = 0;
    for (int m = 0; m <= n * c; m++) begin
      if (m > 0) @(negedge clk);
      busy_cnt += int'(busy[u]);
      done_cnt += int'(done[u]);
      if ((m % c) == (c / 2) && (m / c) < n)
        check($sformatf("%s bit%0d", tag, m / c), 32'(tx[u]), 32'(exp_bits[m / c]));
    end
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(n * c));
    check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " end tx/busy/rdy/done"}, 32'({tx[u], busy[u], rdy[u], done[u]}), 32'b1011);
  endtask

  // Loopback receiver model on u3 (4 clocks per bit, 8 data bits, even parity).
  logic [7:0] rx_q [$];
  int         rx_perr = 0;
  int         rx_serr = 0;
  logic [7:0] rx_d;
  logic       rx_p, rx_s;

  initial begin
    forever begin
      @(negedge tx[3]);
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (tx[3] !== 1'b0) continue;
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        rx_d[i] = tx[3];
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      rx_p = tx[3];
      repeat (4) @(posedge clk);
      @(negedge clk);
      rx_s = tx[3];
      if (((^rx_d) ^ rx_p) !== 1'b0) rx_perr++;
      if (rx_s !== 1'b1) rx_serr++;
      rx_q.push_back(rx_d);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] sent_q [$];
  logic [7:0] rnd;
  int         errs;
  int         w;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vld[i] = 1'b0;
      dat[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("reset u0", 32'({tx[0], rdy[0], busy[0], done[0]}), 32'b1100);
    check("reset u1", 32'({tx[1], rdy[1], busy[1], done[1]}), 32'b1100);
    check("reset u2", 32'({tx[2], rdy[2], busy[2], done[2]}), 32'b1100);
    check("reset u3", 32'({tx[3], rdy[3], busy[3], done[3]}), 32'b1100);
    rst_n = 1'b1;

    // 1: idle with no valid
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({tx[0], rdy[0], busy[0], done[0]} !== 4'b1100) errs++;
    end
    check("t1 idle cycles off", 32'(errs), 32'd0);

    // 2: 0xA5, even parity -> 0,1,0,1,0,0,1,0,1,0,1 over 176 cycles
    run_frame(0, 16, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h5A, "t2");
    @(negedge clk);
    check("t2 done after", 32'({done[0], tx[0], rdy[0]}), 32'b011);

    // 3: odd parity on 0x00 gives parity 1; no parity on 0xFF gives 160 cycles
    run_frame(1, 16, 1'b1, 1'b1, 8'h00, 1'b0, 8'hFF, "t3odd");
    run_frame(2, 16, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, "t3nopar");

    // 4: back-to-back with valid held, data scrambled mid-frame
    run_frame(0, 16, 1'b1, 1'b0, 8'h3C, 1'b1, 8'hFF, "t4a");
    run_frame(0, 16, 1'b1, 1'b0, 8'hC3, 1'b0, 8'h00, "t4b");

    // 5: reset during data bit 3 (frame bit 4) of 0x00
    dat[0] = 8'h00;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (4 * 16 + 5) @(negedge clk);
    check("t5 pre-reset tx", 32'(tx[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t5 async reset", 32'({tx[0], rdy[0], busy[0], done[0]}), 32'b1100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || tx[0] !== 1'b1) errs++;
    end
    check("t5 no done after abort", 32'(errs), 32'd0);
    check("t5 ready after release", 32'(rdy[0]), 32'd1);
    run_frame(0, 16, 1'b1, 1'b0, 8'h55, 1'b0, 8'hAA, "t5");

    // 6: loopback of 256 random words through the receiver model
    for (int i = 0; i < 256; i++) begin
      rnd = 8'($urandom);
      sent_q.push_back(rnd);
      dat[3] = rnd;
      vld[3] = 1'b1;
      @(negedge clk);
      vld[3] = 1'b0;
      w = 0;
      while (done[3] !== 1'b1 && w < 100) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("t6 done %0d", i), 32'(done[3]), 32'd1);
    end
    repeat (8) @(negedge clk);
    check("t6 rx count", 32'(rx_q.size()), 32'd256);
    for (int i = 0; i < 256 && i < rx_q.size(); i++)
      check($sformatf("t6 byte %0d", i), 32'(rx_q[i]), 32'(sent_q[i]));
    check("t6 parity errors", 32'(rx_perr), 32'd0);
    check("t6 stop errors", 32'(rx_serr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
